simon_playback: RTL and testbench



---
 rtl/simon_pkg.sv | 17 +
 rtl/simon_interval_timer.sv | 26 ++
 rtl/simon_playback.sv | 148 ++++++++++++++
 tb/tb_simon_playback.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared Simon constants and playback state encoding.
// Used by both the pattern-entry and playback datapaths.
package simon_pkg;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 4;
    localparam int MEM_DEPTH = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHOW,
        S_GAP,
        S_FINISH
    } state_t;

endpackage

// File: rtl/simon_interval_timer.sv
// Loadable down-counter with a zero flag.
// Saturates at zero so an idle dec is harmless.
module simon_interval_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/simon_playback.sv
// Plays the stored Simon sequence on the pattern LEDs,
// one entry at a time with fixed lit and dark intervals.
module simon_playback #(
    parameter int ADDR_W     = simon_pkg::ADDR_W,
    parameter int DATA_W     = simon_pkg::DATA_W,
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   seq_len,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] leds,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_index
);

    import simon_pkg::*;

    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);
    localparam int IW   = ADDR_W + 1;

    localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);
    localparam logic [IW-1:0] DEPTH  = IW'(1 << ADDR_W);

    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] len;
    logic [IW-1:0] len_in;

    logic          t_load;
    logic          t_dec;
    logic          t_zero;
    logic [TW-1:0] t_val;
    logic [TW-1:0] t_count;

    assign len_in    = (seq_len > DEPTH) ? DEPTH : seq_len;
    assign cur_index = idx[ADDR_W-1:0];

    simon_interval_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (t_load),
        .load_val(t_val),
        .dec     (t_dec),
        .count   (t_count),
        .zero    (t_zero)
    );

    always_comb begin
        t_load = 1'b0;
        t_val  = '0;
        t_dec  = 1'b0;
        if (!abort) begin
            case (state)
                S_FETCH: begin
                    t_load = 1'b1;
                    t_val  = ON_LD;
                end
                S_SHOW: begin
                    if (t_zero) begin
                        t_load = 1'b1;
                        t_val  = OFF_LD;
                    end else begin
                        t_dec = 1'b1;
                    end
                end
                S_GAP:   t_dec = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            leds      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_raddr <= '0;
            idx       <= '0;
            len       <= '0;
        end else begin
            done <= 1'b0;
            // abort outranks any timer expiry in the same cycle
            if (state != S_IDLE && abort) begin
                state <= S_IDLE;
                leds  <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        leds <= '0;
                        if (start) begin
                            busy <= 1'b1;
                            idx  <= '0;
                            len  <= len_in;
                            if (len_in == '0) begin
                                state <= S_FINISH;
                                done  <= 1'b1;
                            end else begin
                                state     <= S_FETCH;
                                mem_raddr <= '0;
                            end
                        end
                    end
                    S_FETCH: begin
                        leds  <= mem_rdata;
                        state <= S_SHOW;
                    end
                    S_SHOW: begin
                        if (t_zero) begin
                            leds  <= '0;
                            state <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (t_zero) begin
                            if (idx == len - 1'b1) begin
                                state <= S_FINISH;
                                done  <= 1'b1;
                            end else begin
                                idx       <= idx + 1'b1;
                                mem_raddr <= ADDR_W'(idx + 1'b1);
                                state     <= S_FETCH;
                            end
                        end
                    end
                    S_FINISH: begin
                        leds  <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_simon_playback.sv
// Self-checking bench for simon_playback: directed table,
// corner-case sequences and random runs against a trace model.
module tb_simon_playback;

    localparam int AW  = 6;
    localparam int DW  = 4;
    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int EL  = 1 + ON + OFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW:0]   seq_len;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] leds;
    logic          busy;
    logic          done;
    logic [AW-1:0] cur_index;

    logic [DW-1:0] mem [64];
    assign mem_rdata = mem[mem_raddr];

    always #5 clk = ~clk;

    simon_playback #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .seq_len  (seq_len),
        .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata),
        .leds     (leds),
        .busy     (busy),
        .done     (done),
        .cur_index(cur_index)
    );

    int checks   = 0;
    int failures = 0;
    int exp_raddr = 0;
    int exp_idx   = 0;

    typedef struct {
        int           len;
        int           mode;
        int           exp_done;
        logic [DW-1:0] exp_last;
        int           exp_ndone;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [17:0] obs();
        return {leds, busy, done, mem_raddr, cur_index};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fill_mem(input int mode);
        for (int j = 0; j < 64; j++) begin
            case (mode)
                0: mem[j] = DW'(4'h1 << (j % 4));
                1: mem[j] = DW'(j);
                2: mem[j] = 4'h4;
                default: mem[j] = DW'($urandom);
            endcase
        end
    endtask

    // Expected per-cycle trace: FETCH dark, ON lit, OFF dark, then FINISH.
    task automatic run_trace(input int l, input bit jitter,
                             output int done_cyc,
                             output logic [DW-1:0] last_led,
                             output int ndone);
        int eff;
        int total;
        eff   = (l > 64) ? 64 : l;
        total = 1 + eff * EL;
        done_cyc = -1;
        last_led = '0;
        ndone    = 0;
        @(negedge clk);
        seq_len = (AW+1)'(l);
        start   = 1'b1;
        for (int k = 1; k <= total + 1; k++) begin
            logic [DW-1:0] e_led;
            logic          e_busy;
            logic          e_done;
            int            e;
            int            p;
            @(negedge clk);
            if (k <= total - 1) begin
                e = (k - 1) / EL;
                p = (k - 1) % EL;
                e_led  = (p >= 1 && p <= ON) ? mem[e] : '0;
                e_busy = 1'b1;
                e_done = 1'b0;
                exp_raddr = e;
                exp_idx   = e;
            end else begin
                e_led  = '0;
                e_busy = (k == total);
                e_done = (k == total);
                exp_idx = (eff == 0) ? 0 : eff - 1;
            end
            chk($sformatf("trace len=%0d cyc=%0d", l, k), 32'(obs()),
                32'({e_led, e_busy, e_done, AW'(exp_raddr), AW'(exp_idx)}));
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (leds != '0) last_led = leds;
            start = (jitter && k <= total) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (jitter) seq_len = (AW+1)'($urandom);
        end
        start = 1'b0;
    endtask

    initial begin
        int            dc;
        int            nd;
        int            seen;
        logic [DW-1:0] ll;

        tbl[0] = '{4,  0, 29,  4'h8, 1};
        tbl[1] = '{0,  0, 1,   4'h0, 1};
        tbl[2] = '{64, 1, 449, 4'hF, 1};
        tbl[3] = '{65, 1, 449, 4'hF, 1};
        tbl[4] = '{2,  2, 15,  4'h4, 1};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        seq_len = '0;
        fill_mem(0);
        repeat (2) @(negedge clk);
        chk("reset_state", 32'(obs()), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            fill_mem(tbl[i].mode);
            run_trace(tbl[i].len, 1'b0, dc, ll, nd);
            chk($sformatf("tbl%0d done_cycle", i), 32'(dc), 32'(tbl[i].exp_done));
            chk($sformatf("tbl%0d last_led", i), 32'(ll), 32'(tbl[i].exp_last));
            chk($sformatf("tbl%0d done_count", i), 32'(nd), 32'(tbl[i].exp_ndone));
        end

        // abort in 2nd SHOW cycle of the first element
        fill_mem(0);
        @(negedge clk);
        seq_len = 7'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_pre_led", 32'(leds), 32'h1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", 32'({leds, busy, done}), 32'h0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'h0);
        exp_raddr = 0;
        exp_idx   = 0;
        run_trace(4, 1'b0, dc, ll, nd);
        chk("replay_done_cycle", 32'(dc), 32'd29);

        // start and abort together in IDLE: start wins
        @(negedge clk);
        seq_len = 7'd2;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'h1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 32'h0);
        exp_raddr = 0;
        exp_idx   = 0;

        // reset during the GAP of the second element
        @(negedge clk);
        seq_len = 7'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("gap2_led_dark", 32'({leds, busy, cur_index}), 32'({4'h0, 1'b1, 6'd1}));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid_gap", 32'(obs()), 32'h0);
        exp_raddr = 0;
        exp_idx   = 0;

        for (int r = 0; r < 6; r++) begin
            fill_mem(3);
            run_trace($urandom_range(0, 70), 1'b1, dc, ll, nd);
            chk($sformatf("rand%0d done_count", r), 32'(nd), 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
